// File: rtl/booth_digit_decoder_pkg.sv
// Shared types and digit decode for the radix-4 Booth decoder.
// The decode function is also used by encoder reference models.
package booth_digit_decoder_pkg;

    typedef logic signed [2:0] digit_t;

    localparam digit_t D_ZERO = 3'sb000;
    localparam digit_t D_P1   = 3'sb001;
    localparam digit_t D_P2   = 3'sb010;
    localparam digit_t D_M1   = 3'sb111;
    localparam digit_t D_M2   = 3'sb110;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEPT = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef struct packed {
        digit_t d;
        logic   illegal;
    } dec_t;

    // An illegal triple (one & two) decodes as zero so conversion can continue.
    function automatic dec_t decode_digit(input logic one, input logic two, input logic sign);
        dec_t r;
        r.illegal = one & two;
        r.d       = D_ZERO;
        if (!r.illegal) begin
            if (two)
                r.d = sign ? D_M2 : D_P2;
            else if (one)
                r.d = sign ? D_M1 : D_P1;
        end
        return r;
    endfunction

endpackage

// File: rtl/booth_digit_decoder_otf_step.sv
// One on-the-fly conversion step: next Q/QM from the current pair and one
// radix-4 digit, using only a 2-bit shift and a constant 2-bit append.
module booth_digit_decoder_otf_step
    import booth_digit_decoder_pkg::*;
#(
    parameter int WQ = 10
) (
    input  logic signed [WQ-1:0] i_q,
    input  logic signed [WQ-1:0] i_qm,
    input  digit_t               i_d,
    output logic signed [WQ-1:0] o_q,
    output logic signed [WQ-1:0] o_qm
);

    logic             w_q_from_qm;
    logic             w_qm_from_qm;
    logic [1:0]       w_q_app;
    logic [1:0]       w_qm_app;
    logic [WQ-1:0]    w_q_src;
    logic [WQ-1:0]    w_qm_src;

    // Append bits are (d mod 4) for Q and ((d-1) mod 4) for QM.
    always_comb begin
        w_q_from_qm  = 1'b0;
        w_qm_from_qm = 1'b1;
        w_q_app      = 2'b00;
        w_qm_app     = 2'b11;
        case (i_d)
            D_P2: begin
                w_q_from_qm  = 1'b0; w_q_app  = 2'b10;
                w_qm_from_qm = 1'b0; w_qm_app = 2'b01;
            end
            D_P1: begin
                w_q_from_qm  = 1'b0; w_q_app  = 2'b01;
                w_qm_from_qm = 1'b0; w_qm_app = 2'b00;
            end
            D_M1: begin
                w_q_from_qm  = 1'b1; w_q_app  = 2'b11;
                w_qm_from_qm = 1'b1; w_qm_app = 2'b10;
            end
            D_M2: begin
                w_q_from_qm  = 1'b1; w_q_app  = 2'b10;
                w_qm_from_qm = 1'b1; w_qm_app = 2'b01;
            end
            default: begin
                w_q_from_qm  = 1'b0; w_q_app  = 2'b00;
                w_qm_from_qm = 1'b1; w_qm_app = 2'b11;
            end
        endcase
    end

    assign w_q_src  = w_q_from_qm  ? i_qm : i_q;
    assign w_qm_src = w_qm_from_qm ? i_qm : i_q;

    assign o_q  = {w_q_src[WQ-3:0],  w_q_app};
    assign o_qm = {w_qm_src[WQ-3:0], w_qm_app};

endmodule

// File: rtl/booth_digit_decoder.sv
// Sequential radix-4 Booth digit to two's-complement decoder, MSB-first,
// with carry-free on-the-fly conversion and overflow/illegal-digit flags.
module booth_digit_decoder
    import booth_digit_decoder_pkg::*;
#(
    parameter int N_DIGITS = 4,
    localparam int W       = 2*N_DIGITS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         digit_valid,
    output logic         digit_ready,
    input  logic         one,
    input  logic         two,
    input  logic         sign,
    output logic         result_valid,
    input  logic         result_ready,
    output logic [W-1:0] result,
    output logic         ovf,
    output logic         err
);

    localparam int WQ = W + 2;
    localparam int CW = $clog2(N_DIGITS + 1);

    state_t               r_state;
    logic signed [WQ-1:0] r_q;
    logic signed [WQ-1:0] r_qm;
    logic [CW-1:0]        r_cnt;
    logic                 r_err;
    logic [W-1:0]         r_result;
    logic                 r_ovf;
    logic                 r_err_out;

    dec_t                 w_dec;
    logic signed [WQ-1:0] w_q_nxt;
    logic signed [WQ-1:0] w_qm_nxt;
    logic                 w_accept;
    logic                 w_last;
    logic [2:0]           w_top;

    assign w_dec    = decode_digit(one, two, sign);
    assign w_accept = digit_valid && (r_state == ACCEPT);
    assign w_last   = (r_cnt == CW'(N_DIGITS - 1));
    assign w_top    = w_q_nxt[WQ-1:W-1];

    booth_digit_decoder_otf_step #(.WQ(WQ)) u_step (
        .i_q  (r_q),
        .i_qm (r_qm),
        .i_d  (w_dec.d),
        .o_q  (w_q_nxt),
        .o_qm (w_qm_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_q       <= '0;
            r_qm      <= '1;
            r_cnt     <= '0;
            r_err     <= 1'b0;
            r_result  <= '0;
            r_ovf     <= 1'b0;
            r_err_out <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_q     <= '0;
                        r_qm    <= '1;
                        r_cnt   <= '0;
                        r_err   <= 1'b0;
                        r_state <= ACCEPT;
                    end
                end
                ACCEPT: begin
                    if (w_accept) begin
                        r_q   <= w_q_nxt;
                        r_qm  <= w_qm_nxt;
                        r_cnt <= r_cnt + 1'b1;
                        r_err <= r_err | w_dec.illegal;
                        // Output registers load only here so they hold through IDLE.
                        if (w_last) begin
                            r_result  <= w_q_nxt[W-1:0];
                            r_ovf     <= !((w_top == 3'b000) || (w_top == 3'b111));
                            r_err_out <= r_err | w_dec.illegal;
                            r_state   <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (result_ready)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign digit_ready  = (r_state == ACCEPT);
    assign result_valid = (r_state == DONE);
    assign result       = r_result;
    assign ovf          = r_ovf;
    assign err          = r_err_out;

endmodule
